// File: rtl/ram_ring_ctrl_pkg.sv
// Shared defaults and width helpers for the ring-buffer RAM address controller.
package ram_ring_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_WR_W   = 16;
  localparam int unsigned DEF_RD_W   = 64;

  function automatic int unsigned bank_idx_w(input int unsigned bank_num);
    return $clog2(bank_num);
  endfunction

  // Width of the in-bank offset field of an address of addr_w bits.
  function automatic int unsigned off_w(input int unsigned addr_w, input int unsigned bank_num);
    return addr_w - $clog2(bank_num);
  endfunction

endpackage

// File: rtl/ram_rd_lat_pipe.sv
// Read-latency pipe: delays the RAM read strobe by RD_LAT cycles and captures
// RAM read data on the delayed strobe.
module ram_rd_lat_pipe
  import ram_ring_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_RD_W,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ren,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_vld
);

  logic [RD_LAT-1:0] vld_sr_q, vld_sr_d;
  logic [RD_LAT:0]   vld_sr_ext;
  logic              vld_dly;

  // Extended vector keeps the shift well-formed for RD_LAT == 1.
  always_comb begin
    vld_sr_ext = {vld_sr_q, ren};
    vld_sr_d   = vld_sr_ext[RD_LAT-1:0];
    vld_dly    = vld_sr_q[RD_LAT-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_sr_q  <= '0;
      rdata_vld <= 1'b0;
      rdata     <= '0;
    end else begin
      vld_sr_q  <= vld_sr_d;
      rdata_vld <= vld_dly;
      if (vld_dly) begin
        rdata <= ram_rdata;
      end
    end
  end

endmodule

// File: rtl/ram_ring_ctrl.sv
// RAM ring controller: BANK_NUM banks written in bursts and read in wide beats.
// Optional stall statistics counters are enabled with `define RAMC_STAT_EN.
module ram_ring_ctrl
  import ram_ring_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BANK_NUM  = 4,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned WR_W      = DEF_WR_W,
  parameter int unsigned RD_W      = DEF_RD_W,
  parameter int unsigned RD_LAT    = 2,
  localparam int unsigned BANK_W   = bank_idx_w(BANK_NUM),
  localparam int unsigned RA_W     = ADDR_W - $clog2(RD_W / WR_W),
  localparam int unsigned CNT_W    = BANK_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_vaild,
  input  logic              w_ready,
  output logic              w_req,
  output logic              r_fifo,
  output logic [ADDR_W-1:0] ram_waddr,
  input  logic              r_o_vaild,
  output logic              r_o_ready,
  output logic              ram_ren,
  output logic [RA_W-1:0]   ram_raddr,
  input  logic [RD_W-1:0]   ram_rdata,
  output logic [RD_W-1:0]   rdata,
  output logic              rdata_vld,
  output logic [CNT_W-1:0]  bank_cnt
`ifdef RAMC_STAT_EN
  ,
  output logic [15:0]       ovf_cnt,
  output logic [15:0]       unf_cnt
`endif
);

  localparam int unsigned      WOFF_W   = off_w(ADDR_W, BANK_NUM);
  localparam int unsigned      ROFF_W   = off_w(RA_W, BANK_NUM);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BANK_NUM);

  logic [ADDR_W-1:0] waddr_q, waddr_d, waddr_inc;
  logic [RA_W-1:0]   raddr_q, raddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              w_acc, r_acc, wr_done, rd_done;

  always_comb begin
    w_req     = w_vaild & (cnt_q != CNT_FULL);
    w_acc     = w_req & w_ready;
    waddr_inc = waddr_q + ADDR_W'(BURST_LEN);
    wr_done   = w_acc & (waddr_inc[WOFF_W-1:0] == '0);
    r_o_ready = (cnt_q != '0);
    r_acc     = r_o_vaild & r_o_ready;
    rd_done   = r_acc & (&raddr_q[ROFF_W-1:0]);
    waddr_d   = w_acc ? waddr_inc : waddr_q;
    raddr_d   = r_acc ? raddr_q + RA_W'(1) : raddr_q;
    cnt_d     = cnt_q;
    if (wr_done && !rd_done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (rd_done && !wr_done) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waddr_q <= '0;
      raddr_q <= '0;
      cnt_q   <= '0;
    end else begin
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign r_fifo    = w_acc;
  assign ram_ren   = r_acc;
  assign ram_waddr = waddr_q;
  assign ram_raddr = raddr_q;
  assign bank_cnt  = cnt_q;

  ram_rd_lat_pipe #(
    .DATA_W (RD_W),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .reset     (reset),
    .ren       (r_acc),
    .ram_rdata (ram_rdata),
    .rdata     (rdata),
    .rdata_vld (rdata_vld)
  );

`ifdef RAMC_STAT_EN
  logic [15:0] ovf_q, unf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= '0;
      unf_q <= '0;
    end else begin
      if (w_vaild && (cnt_q == CNT_FULL) && (ovf_q != 16'hFFFF)) begin
        ovf_q <= ovf_q + 16'd1;
      end
      if (r_o_vaild && !r_o_ready && (unf_q != 16'hFFFF)) begin
        unf_q <= unf_q + 16'd1;
      end
    end
  end

  assign ovf_cnt = ovf_q;
  assign unf_cnt = unf_q;
`endif

  bank_cnt_range: assert property (@(posedge clk) disable iff (!reset) cnt_q <= CNT_FULL);

endmodule

// File: tb/tb_ram_ring_ctrl.sv
// Directed bench for ram_ring_ctrl: 2-bank ring, 8-bit word address, 16/64-bit words.
module tb_ram_ring_ctrl;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned RA_W   = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              w_vaild, w_ready, r_o_vaild;
  logic              w_req, r_fifo, r_o_ready, ram_ren, rdata_vld;
  logic [ADDR_W-1:0] ram_waddr;
  logic [RA_W-1:0]   ram_raddr;
  logic [63:0]       ram_rdata, rdata;
  logic [1:0]        bank_cnt;
`ifdef RAMC_STAT_EN
  logic [15:0]       ovf_cnt, unf_cnt;
`endif

  ram_ring_ctrl #(
    .ADDR_W    (8),
    .BANK_NUM  (2),
    .BURST_LEN (8),
    .WR_W      (16),
    .RD_W      (64),
    .RD_LAT    (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .w_vaild   (w_vaild),
    .w_ready   (w_ready),
    .w_req     (w_req),
    .r_fifo    (r_fifo),
    .ram_waddr (ram_waddr),
    .r_o_vaild (r_o_vaild),
    .r_o_ready (r_o_ready),
    .ram_ren   (ram_ren),
    .ram_raddr (ram_raddr),
    .ram_rdata (ram_rdata),
    .rdata     (rdata),
    .rdata_vld (rdata_vld),
    .bank_cnt  (bank_cnt)
`ifdef RAMC_STAT_EN
    ,
    .ovf_cnt   (ovf_cnt),
    .unf_cnt   (unf_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int wcount = 0;
  int rbeat  = 0;

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] mem [256];
  logic [63:0] st1, st2;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Beat k of the read stream carries write words 4k..4k+3 (data = write index).
  function automatic logic [63:0] beat_data(input int k);
    logic [15:0] w0, w1, w2, w3;
    w0 = 16'(4 * k);
    w1 = 16'(4 * k + 1);
    w2 = 16'(4 * k + 2);
    w3 = 16'(4 * k + 3);
    return {w3, w2, w1, w0};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: 2-cycle read latency, bursts written when r_fifo pulses.
  always @(posedge clk) begin
    logic [7:0] base;
    base = {ram_raddr, 2'b00};
    if (ram_ren) st1 <= {mem[base + 8'd3], mem[base + 8'd2], mem[base + 8'd1], mem[base]};
    st2 <= st1;
  end
  assign ram_rdata = st2;

  always @(negedge clk) begin
    if (reset) begin
      if (r_fifo) begin
        for (int i = 0; i < 8; i++) mem[8'(ram_waddr + 8'(i))] = 16'(wcount + i);
        wcount += 8;
      end
      if (rdata_vld) begin
        if (exp_q.size() == 0) begin
          chk("rdata_vld_unexpected", 64'(rdata_vld), 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rdata", rdata, e.data);
          chk("rd_latency", 64'(cyc - e.cyc), 64'd3);
        end
      end
      if (ram_ren) begin
        exp_q.push_back('{cyc, beat_data(rbeat)});
        rbeat++;
      end
    end else begin
      chk("rdata_vld_in_reset", 64'(rdata_vld), 64'd0);
    end
  end

  typedef struct {
    int         n;
    logic       wv, wr, rv;
    int         fifo, ren;
    logic       wreq;
    logic [7:0] waddr;
    logic [5:0] raddr;
    logic [1:0] cnt;
    logic       rdy;
  } row_t;

  row_t rows [12];

  task automatic run_row(input row_t r);
    int   fifo_n, ren_n;
    logic wreq_last;
    fifo_n = 0;
    ren_n  = 0;
    wreq_last = 1'b0;
    for (int c = 0; c < r.n; c++) begin
      w_vaild   = r.wv;
      w_ready   = r.wr;
      r_o_vaild = r.rv;
      #1;
      fifo_n += int'(r_fifo);
      ren_n  += int'(ram_ren);
      wreq_last = w_req;
      @(posedge clk);
      #1;
    end
    chk("r_fifo_pulses", 64'(fifo_n), 64'(r.fifo));
    chk("ram_ren_pulses", 64'(ren_n), 64'(r.ren));
    chk("w_req", 64'(wreq_last), 64'(r.wreq));
    chk("ram_waddr", 64'(ram_waddr), 64'(r.waddr));
    chk("ram_raddr", 64'(ram_raddr), 64'(r.raddr));
    chk("bank_cnt", 64'(bank_cnt), 64'(r.cnt));
    chk("r_o_ready", 64'(r_o_ready), 64'(r.rdy));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_waddr"}, 64'(ram_waddr), 64'd0);
    chk({tag, "_raddr"}, 64'(ram_raddr), 64'd0);
    chk({tag, "_cnt"}, 64'(bank_cnt), 64'd0);
    chk({tag, "_ready"}, 64'(r_o_ready), 64'd0);
    chk({tag, "_ren"}, 64'(ram_ren), 64'd0);
    chk({tag, "_vld"}, 64'(rdata_vld), 64'd0);
    chk({tag, "_rdata"}, rdata, 64'd0);
`ifdef RAMC_STAT_EN
    chk({tag, "_ovf"}, 64'(ovf_cnt), 64'd0);
    chk({tag, "_unf"}, 64'(unf_cnt), 64'd0);
`endif
  endtask

  initial begin
    //          n    wv wr rv fifo ren wreq waddr  raddr  cnt rdy
    rows[0]  = '{15,  1, 1, 0, 15,   0, 1, 8'h78, 6'h00, 0, 0};  // bank not yet complete
    rows[1]  = '{1,   1, 1, 0, 1,    0, 1, 8'h80, 6'h00, 1, 1};  // 16th burst completes bank 0
    rows[2]  = '{16,  1, 1, 0, 16,   0, 1, 8'h00, 6'h00, 2, 1};  // ring full
    rows[3]  = '{5,   1, 1, 0, 0,    0, 0, 8'h00, 6'h00, 2, 1};  // writer blocked
    rows[4]  = '{32,  0, 1, 1, 0,   32, 0, 8'h00, 6'h20, 1, 1};  // drain bank 0
    rows[5]  = '{16,  0, 1, 1, 0,   16, 0, 8'h00, 6'h30, 1, 1};  // half of bank 1
    rows[6]  = '{16,  1, 1, 1, 16,  16, 1, 8'h80, 6'h00, 1, 1};  // complete+finish same cycle
    rows[7]  = '{192, 1, 1, 1, 96, 192, 0, 8'h80, 6'h00, 1, 1};  // three ring laps
    rows[8]  = '{32,  0, 1, 1, 0,   32, 0, 8'h80, 6'h20, 0, 0};  // drain to empty
    rows[9]  = '{2,   0, 1, 1, 0,    0, 0, 8'h80, 6'h20, 0, 0};  // reader stalled
    rows[10] = '{20,  1, 1, 1, 20,   4, 1, 8'h20, 6'h24, 1, 1};  // mid-burst, reads in flight
    rows[11] = '{16,  1, 1, 0, 16,   0, 1, 8'h80, 6'h00, 1, 1};  // restart after reset

    reset = 1'b0;
    w_vaild = 1'b0;
    w_ready = 1'b0;
    r_o_vaild = 1'b0;
    st1 = '0;
    st2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("rst");
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      if (i == 11) begin
        // Reset while a bank is full and reads are still in the RAM pipe.
        w_vaild = 1'b0;
        w_ready = 1'b0;
        r_o_vaild = 1'b1;
        reset = 1'b0;
        exp_q.delete();
        rbeat = 0;
        wcount = 0;
        #1;
        chk_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        r_o_vaild = 1'b0;
        reset = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_vld", 64'(rdata_vld), 64'd0);
      end
      run_row(rows[i]);
`ifdef RAMC_STAT_EN
      if (i == 3) chk("ovf_cnt", 64'(ovf_cnt), 64'd5);
      if (i == 9) chk("unf_cnt", 64'(unf_cnt), 64'd2);
`endif
    end

    w_vaild = 1'b0;
    w_ready = 1'b0;
    r_o_vaild = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
    chk("beats_read", 64'(rbeat), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_ring_ctrl.md
Name: ram_ring_ctrl

Overview:
- Parametrised successor of the two-bank ping-pong RAM address controller.
- Manages an external RAM as a ring of BANK_NUM equal banks.
- Write side: accepts fixed-length bursts of WR_W words from an upstream FIFO. Read side: delivers RD_W words to a downstream consumer.
- Tracks full banks, stalls the reader on empty and the writer on full, and delays a read-data valid to match RAM latency.

Parameters:
- ADDR_W, 10, write word address width (RAM depth = 2^ADDR_W WR_W-words).
- BANK_NUM, 4, number of banks; power of 2, 2..16.
- BURST_LEN, 8, WR_W words per write burst; power of 2; must divide the bank size.
- WR_W, 16, write word width.
- RD_W, 64, read word width; RD_W/WR_W is a power of 2.
- RD_LAT, 2, RAM read latency in cycles (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-low reset.
- w_vaild  in  1  upstream FIFO holds >= BURST_LEN words.
- w_ready  in  1  RAM controller accepts a burst this cycle.
- w_req  out  1  burst request to RAM controller.
- r_fifo  out  1  one-cycle pulse: upstream pops one burst.
- ram_waddr  out  ADDR_W  current burst start address, in WR_W words.
- r_o_vaild  in  1  consumer requests one RD_W beat.
- r_o_ready  out  1  at least one full bank is readable.
- ram_ren  out  1  read strobe to RAM.
- ram_raddr  out  ADDR_W-log2(RD_W/WR_W)  read address, in RD_W words.
- ram_rdata  in  RD_W  RAM read data.
- rdata  out  RD_W  read data to consumer.
- rdata_vld  out  1  rdata valid.
- bank_cnt  out  log2(BANK_NUM)+1  number of full, unread banks.

Behaviour:
Reset values:
- All outputs 0; ram_waddr = 0, ram_raddr = 0, bank_cnt = 0.
- Write and read pointers both start at bank 0.

Write side:
- w_req = w_vaild & (bank_cnt != BANK_NUM), combinational.
- A burst is accepted when w_req & w_ready.
- On accept: r_fifo pulses in the same cycle, and ram_waddr += BURST_LEN at the next edge.
- ram_waddr wraps modulo 2^ADDR_W; the top log2(BANK_NUM) bits form the write bank index.
- Bank completes when an accepted burst's new address has all in-bank offset bits 0.

Read side:
- r_o_ready = (bank_cnt != 0), driven from the registered count.
- A beat is accepted when r_o_vaild & r_o_ready: ram_ren = 1 that cycle, and ram_raddr increments at the next edge, wrapping.
- Bank finishes when the accepted beat has all in-bank offset bits 1.

bank_cnt:
- +1 on write bank complete, -1 on read bank finish.
- Both in the same cycle: unchanged.
- Never exceeds BANK_NUM, never goes below 0. Gating guarantees this; an assertion checks it.

Full/empty:
- At bank_cnt = BANK_NUM, w_req = 0; the writer holds in the reader's current bank until that bank finishes.
- At bank_cnt = 0, r_o_ready = 0.
- Reader stall: last beat of the last full bank accepted → ready drops the next cycle.

Read data path:
- rdata_vld is ram_ren delayed RD_LAT cycles through a shift register.
- rdata is registered from ram_rdata when the delayed strobe is high, and holds otherwise.
- Total latency = RD_LAT + 1 cycles from accept.

Reset mid-operation: all pointers, count and pipeline clear; in-flight read data is discarded.

Optional Feature:
RAMC_STAT_EN:
- Defined: adds two ports.
  - ovf_cnt out 16: counts cycles with w_vaild=1 and bank_cnt=BANK_NUM (writer blocked).
  - unf_cnt out 16: counts cycles with r_o_vaild=1 and r_o_ready=0.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Shared gen_defines package: ADDR_W/RD_W/WR_W defaults, bank-index and offset-width helper constants.
- One natural sub-module: ram_rd_lat_pipe, the RD_LAT valid shift register plus rdata capture register, reusable by other RAM clients.
- All state registers built from the team's gnrl dfflr cells.

Test Plan:
All scenarios use ADDR_W=8, BANK_NUM=2, BURST_LEN=8, WR_W=16, RD_W=64, RD_LAT=2. Bank = 128 words = 16 bursts = 32 read beats.
- Reset then w_vaild=w_ready=1 for 16 cycles → 16 r_fifo pulses; ram_waddr = 0x80; bank_cnt = 1; r_o_ready rises the cycle after the 16th accept.
- 32 writes with no reads → bank_cnt = 2; w_req stays 0 while w_vaild = 1; ram_waddr holds 0x00.
- From bank_cnt=1, r_o_vaild=1 for 32 cycles → ram_raddr 0..31, rdata_vld 3 cycles after each ram_ren; bank_cnt = 0; r_o_ready falls the next cycle.
- Final write burst and final read beat of different banks accepted in the same cycle → bank_cnt unchanged.
- Continuous writes and reads across 3 full ring laps → both pointers wrap to 0 correctly; no under/overflow; read data matches written pattern.
- Assert reset mid-burst with bank_cnt=1 → all outputs 0 next cycle; with RAMC_STAT_EN, ovf_cnt/unf_cnt read 0.
